// File: rtl/unified_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the unified instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   arb_owner_t : which core port won arbitration
//   STARVE_W    : width of the fetch starvation counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter_if
// Bundles the three buses around the arbiter: the core fetch port (i_*),
// the core data port (d_*) and the single-port memory macro (m_*).
//   modport slave  : arbiter view (takes core requests, drives memory)
//   modport master : environment view (core ports and memory macro)
// Parameters: AW address width, DW data width.
// ---------------------------------------------------------------------------
interface unified_mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // fetch port
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_valid;
   // data port
   logic          d_req;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_we;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   // memory side
   logic          m_req;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_we;
   logic [DW-1:0] m_rdata;
   logic          m_valid;

   modport slave (
      input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_valid,
      output i_rdata, i_valid, d_rdata, d_valid, m_req, m_addr, m_wdata, m_we
   );

   modport master (
      output i_req, i_addr, d_req, d_addr, d_wdata, d_we, m_rdata, m_valid,
      input  i_rdata, i_valid, d_rdata, d_valid, m_req, m_addr, m_wdata, m_we
   );

endinterface

// File: rtl/unified_mem_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// arb_starve_ctr
// Saturating counter of data grants made while a fetch is waiting.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : count one more starving data grant (saturates at MAX)
//   clr          : clear (fetch was granted); wins over inc
//   at_max       : counter has reached MAX, fetch must be served next
// Parameter MAX : saturation value, 1..15.
// ---------------------------------------------------------------------------
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

   logic [STARVE_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_C)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_max = (cnt >= MAX_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-port memory between the core's fetch port and data
// port. One transaction is outstanding at a time. The data port has fixed
// priority; after STARVE_MAX consecutive data grants with a fetch pending,
// the fetch is forced through.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : unified_mem_arbiter_if.slave (i_*, d_*, m_* signals)
//   perf_*       : 32-bit saturating grant/conflict counters, present only
//                  when the ARB_PERF_CNT_EN macro is defined
//
// Parameters: AW address width, DW data width, STARVE_MAX (1..15).
// Optional feature macro: ARB_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   unified_mem_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]            perf_i_grants,
   output logic [31:0]            perf_d_grants,
   output logic [31:0]            perf_conflict
`endif
);

   arb_state_t    state;
   arb_owner_t    winner;
   logic          grant;
   logic          at_max;
   logic          starve_inc;
   logic          starve_clr;

   logic          m_req_q;
   logic          m_we_q;
   logic [AW-1:0] m_addr_q;
   logic [DW-1:0] m_wdata_q;

   // Arbitration only happens in IDLE; data wins unless a fetch is waiting
   // and the starvation counter has run out.
   always_comb begin
      grant  = 1'b0;
      winner = OWN_I;
      if (state == IDLE) begin
         if (bus.d_req && (!bus.i_req || !at_max)) begin
            grant  = 1'b1;
            winner = OWN_D;
         end else if (bus.i_req) begin
            grant  = 1'b1;
            winner = OWN_I;
         end
      end
   end

   // Only data grants that actually bypass a waiting fetch count as starving.
   assign starve_inc = grant && (winner == OWN_D) && bus.i_req;
   assign starve_clr = grant && (winner == OWN_I);

   arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (starve_inc),
      .clr     (starve_clr),
      .at_max  (at_max)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         m_req_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  m_req_q <= 1'b1;
                  if (winner == OWN_D) begin
                     m_addr_q  <= bus.d_addr;
                     m_wdata_q <= bus.d_wdata;
                     m_we_q    <= bus.d_we;
                     state     <= BUSY_D;
                  end else begin
                     // Fetches never write; write data is left as is.
                     m_addr_q  <= bus.i_addr;
                     m_we_q    <= 1'b0;
                     state     <= BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               if (bus.m_valid) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.m_req   = m_req_q;
   assign bus.m_we    = m_we_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;

   // Completion is passed straight through so the owner sees it in the same
   // cycle as the memory; m_valid outside a BUSY state is dropped.
   assign bus.i_valid = (state == BUSY_I) && bus.m_valid;
   assign bus.d_valid = (state == BUSY_D) && bus.m_valid;
   assign bus.i_rdata = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;

`ifdef ARB_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_i_grants <= '0;
         perf_d_grants <= '0;
         perf_conflict <= '0;
      end else begin
         if (grant && (winner == OWN_I)) begin
            perf_i_grants <= sat_inc(perf_i_grants);
         end
         if (grant && (winner == OWN_D)) begin
            perf_d_grants <= sat_inc(perf_d_grants);
         end
         if ((state == IDLE) && bus.i_req && bus.d_req) begin
            perf_conflict <= sat_inc(perf_conflict);
         end
      end
   end
`endif

endmodule
